switch_debounce: RTL
====================

# switch_debounce

Synchronizing debouncer for raw board push-buttons and switches. It sits directly upstream of the switch-driven logic stages, such as the two-input AND-gate LED project, and replaces raw `i_Switch_*` pin connections with clean, metastability-safe levels. Each channel runs a two-flop synchronizer and a stability counter. Each channel also produces one-cycle edge pulses for downstream counters and state machines.

## Interface
Parameters:
- `NUM_SW`, default 2: number of independent switch channels, ≥1.
- `DEBOUNCE_LIMIT`, default 250000 (10 ms at 25 MHz): consecutive stable cycles required to accept a new level, ≥1.

Ports:
- `i_Clk`  input  1  system clock. All logic is on the rising edge.
- `i_Rst_L`  input  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `i_Switch`  input  NUM_SW  raw asynchronous switch pins, one bit per channel.
- `o_Switch`  output  NUM_SW  debounced switch levels. Channel n connects to downstream `i_Switch_(n+1)`.
- `o_Rise`  output  NUM_SW  one-cycle pulse when a channel's debounced level goes 0→1.
- `o_Fall`  output  NUM_SW  one-cycle pulse when a channel's debounced level goes 1→0.

## Operation
- Synchronizer per channel: `s1 <= i_Switch[n]`, then `s2 <= s1`. Only `s2` is used downstream of the synchronizer.
- Counter per channel is `$clog2(DEBOUNCE_LIMIT+1)` bits wide, unsigned, and never wraps.
- On each edge, per channel:
  - If `s2 == o_Switch[n]`: count <= 0.
  - Else if count == DEBOUNCE_LIMIT-1: o_Switch[n] <= s2, count <= 0, and pulse `o_Rise[n]` (if s2=1) or `o_Fall[n]` (if s2=0).
  - Else: count <= count+1.
- Any return of `s2` to the current output level before the limit discards the partial count. There is no hysteresis memory.
- `o_Rise` and `o_Fall` are registered. They default to 0 every cycle unless set by the update branch. Both are never high together on the same channel.
- Channels are fully independent. Simultaneous changes on several channels update in the same cycle if their timing is identical.
- DEBOUNCE_LIMIT=1: a single cycle of disagreement in `s2` is accepted.

## Timing
- Reset (`i_Rst_L`=0 at an edge) clears the following: `s1`, `s2`, all counters, `o_Switch`=0, `o_Rise`=0, `o_Fall`=0.
- Reset takes priority over everything, including a pending update in the same cycle.
- Reset mid-count discards progress. After release, a still-changed input needs the full latency again.
- Latency: a new level is stable at the pin before edge E1, where E1 is the first edge that samples it.
  - `o_Switch` changes at edge E(DEBOUNCE_LIMIT+2).
  - The matching edge pulse is high for exactly the one cycle following that edge.
- Pulses shorter than DEBOUNCE_LIMIT cycles, as seen at `s2`, never reach `o_Switch`.
- No combinational path exists from `i_Switch` to any output. All outputs are flop-driven.
- Minimum interval between consecutive transitions on one channel is DEBOUNCE_LIMIT cycles.

## Test plan
All scenarios use NUM_SW=2 and DEBOUNCE_LIMIT=4, with a 10 ns clock.
1. Reset hold:
   - Stimulus: `i_Rst_L`=0 for 5 cycles with `i_Switch`=2'b11.
   - Response: `o_Switch`=00 and `o_Rise`=`o_Fall`=00 every cycle. After release, `o_Switch`=11 exactly at the 6th edge.
2. Clean press and release, channel 0:
   - Stimulus: `i_Switch` 00→01, held.
   - Response: `o_Switch`=01 at the 6th edge, with `o_Rise`=01 for exactly one cycle.
   - Stimulus: then 01→00, held.
   - Response: `o_Switch`=00 at the 6th edge, with `o_Fall`=01 for one cycle.
3. Bounce rejection:
   - Stimulus: channel 1 toggles high 3 cycles / low 2 cycles, five times, then stays low.
   - Response: `o_Switch[1]`=0 throughout, with no `o_Rise` or `o_Fall` pulse.
4. Bounce then settle:
   - Stimulus: channel 0 does 3 cycles high, 1 low, then stays high.
   - Response: `o_Switch[0]` rises exactly 6 edges after the final 0→1, with a single `o_Rise[0]` pulse.
5. Simultaneous press feeding the AND-gate stage:
   - Stimulus: `i_Switch` 00→11, with `o_Switch` wired to `And_Gate_Project`.
   - Response: `o_Switch`=11 and `o_Rise`=11 in the same cycle; `o_LED_1`=1 from that cycle on. Releasing channel 1 only gives `o_LED_1`=0 after 6 edges.
6. Reset mid-count:
   - Stimulus: `i_Switch`=01; assert reset at the 4th edge, release one cycle later, input still 01.
   - Response: `o_Switch`=00 until the 6th edge after release, then 01 with one `o_Rise[0]` pulse.

Source files
------------

// File: rtl/switch_debounce.sv
// Purpose: per-channel two-flop synchronizer + stability counter debouncer with edge pulses.
// Latency: new pin level reaches o_Switch at the (DEBOUNCE_LIMIT+2)-th sampling edge.
// Backpressure: none; free-running level path, pulses are single-cycle and unqualified.
module switch_debounce #(
  parameter int NUM_SW         = 2,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch,
  output logic [NUM_SW-1:0] o_Rise,
  output logic [NUM_SW-1:0] o_Fall
);

  // Counter only ever needs to reach DEBOUNCE_LIMIT-1; width leaves headroom so it cannot wrap.
  localparam int CNT_W = (DEBOUNCE_LIMIT < 1) ? 1 : $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [NUM_SW-1:0] s1;
  logic [NUM_SW-1:0] s2;

  // Two-flop synchronizer for the asynchronous pins; only s2 feeds the debounce logic.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= i_Switch;
      s2 <= s1;
    end
  end

  for (genvar n = 0; n < NUM_SW; n++) begin : g_chan
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             sw_q;
    logic             sw_nxt;
    logic             rise_q;
    logic             rise_nxt;
    logic             fall_q;
    logic             fall_nxt;

    // Next-state: any agreement with the current level discards partial progress;
    // the last disagreeing cycle commits the new level and fires the matching pulse.
    always_comb begin
      count_nxt = count;
      sw_nxt    = sw_q;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      if (s2[n] == sw_q) begin
        count_nxt = '0;
      end else if (count == CNT_LAST) begin
        count_nxt = '0;
        sw_nxt    = s2[n];
        rise_nxt  = s2[n];
        fall_nxt  = ~s2[n];
      end else begin
        count_nxt = count + CNT_W'(1);
      end
    end

    // Channel state register; reset overrides any update committing on the same edge.
    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        count  <= '0;
        sw_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        count  <= count_nxt;
        sw_q   <= sw_nxt;
        rise_q <= rise_nxt;
        fall_q <= fall_nxt;
      end
    end

    assign o_Switch[n] = sw_q;
    assign o_Rise[n]   = rise_q;
    assign o_Fall[n]   = fall_q;
  end

endmodule
